// File: rtl/mem_pkg.sv
// Shared encodings for the load/store front end: access sizes, FSM states,
// memory depth and the alignment rule.
package mem_pkg;

  localparam int WORDS = 128;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WRITE  = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  // Size 2'b11 is illegal and is folded into the misaligned path.
  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SIZE_B:  is_aligned = 1'b1;
      SIZE_H:  is_aligned = ~lo[0];
      SIZE_W:  is_aligned = (lo == 2'b00);
      default: is_aligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// Request/response channel between the datapath (master) and the load/store unit (slave).
// Handshake: a request transfers on the rising edge where req_valid && req_ready;
// resp_valid is a one-cycle pulse with no back-pressure.
interface mem_access_if #(parameter int ADDR_W = 9);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/mem_access_unit_align.sv
// Stateless lane logic: little-endian extraction/extension for loads and
// lane merge into the fetched word for sub-word stores.
module lsu_align
  import mem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        uns_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merged_o
);

  logic [4:0]  byte_sh;
  logic [4:0]  half_sh;
  logic [7:0]  byte_val;
  logic [15:0] half_val;

  always_comb begin
    byte_sh  = {lane_i, 3'b000};
    half_sh  = {lane_i[1], 4'b0000};
    byte_val = 8'(word_i >> byte_sh);
    half_val = 16'(word_i >> half_sh);

    case (size_i)
      SIZE_B:  load_o = uns_i ? {24'h0, byte_val} : {{24{byte_val[7]}}, byte_val};
      SIZE_H:  load_o = uns_i ? {16'h0, half_val} : {{16{half_val[15]}}, half_val};
      default: load_o = word_i;
    endcase

    case (size_i)
      SIZE_B:  merged_o = (word_i & ~(32'h0000_00FF << byte_sh)) |
                          ({24'h0, wdata_i[7:0]} << byte_sh);
      SIZE_H:  merged_o = (word_i & ~(32'h0000_FFFF << half_sh)) |
                          ({16'h0, wdata_i[15:0]} << half_sh);
      default: merged_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front end for a word-only data memory: one request at a time,
// read-modify-write for sub-word stores, misaligned requests answered with err.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  mem_access_if.slave       bus,
  output logic              mem_wea,
  output logic [ADDR_W-3:0] mem_addra,
  output logic [31:0]       mem_dina,
  output logic [ADDR_W-3:0] mem_addrb,
  input  logic [31:0]       mem_doutb,
  output state_t            state_o
);

  state_t            state_q, state_d;
  logic              we_q, uns_q, err_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q, merged_q, rdata_q;
  logic [31:0]       load_data, merged_data;
  logic              accept;
  logic              req_aligned;

  assign req_aligned = is_aligned(bus.req_size, bus.req_addr[1:0]);
  assign accept      = bus.req_valid && bus.req_ready;

  lsu_align u_align (
    .size_i   (size_q),
    .uns_i    (uns_q),
    .lane_i   (addr_q[1:0]),
    .word_i   (mem_doutb),
    .wdata_i  (wdata_q),
    .load_o   (load_data),
    .merged_o (merged_data)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (bus.req_valid) state_d = req_aligned ? ST_ACCESS : ST_RESP;
      ST_ACCESS: state_d = (we_q && size_q != SIZE_W) ? ST_WRITE : ST_RESP;
      ST_WRITE:  state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Write enable is gated by rst so an in-flight store is dropped on reset.
  always_comb begin
    bus.req_ready  = (state_q == ST_IDLE) && !rst;
    bus.resp_valid = (state_q == ST_RESP) && !rst;
    bus.resp_rdata = rdata_q;
    bus.resp_err   = err_q;
    mem_addra      = addr_q[ADDR_W-1:2];
    mem_addrb      = addr_q[ADDR_W-1:2];
    mem_dina       = (state_q == ST_WRITE) ? merged_q : wdata_q;
    mem_wea        = !rst && (((state_q == ST_ACCESS) && we_q && (size_q == SIZE_W)) ||
                              (state_q == ST_WRITE));
    state_o        = state_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q     <= 1'b0;
      uns_q    <= 1'b0;
      size_q   <= SIZE_B;
      addr_q   <= '0;
      wdata_q  <= '0;
      merged_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      if (accept) begin
        we_q    <= bus.req_we;
        uns_q   <= bus.req_unsigned;
        size_q  <= bus.req_size;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        rdata_q <= '0;
        err_q   <= !req_aligned;
      end
      if (state_q == ST_ACCESS) begin
        if (!we_q) rdata_q <= load_data;
        merged_q <= merged_data;
      end
    end
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store front end for the data memory in the multi-cycle CPU: accepts one byte/halfword/word request at a time from the datapath over a valid/ready handshake and drives the memory's write port (`wea`/`addra`/`dina`) and read port (`addrb`/`doutb`). The memory stores only full 32-bit words, so sub-word stores use an internal read-modify-write sequence. Loads are sign- or zero-extended, and misaligned accesses are rejected with an error response.

## Interface
Parameters:
- `ADDR_W`, 9: byte-address width; the word address is `ADDR_W-2` = 7 bits, for 128 words.

Ports:
- One clock; reset is synchronous and active-high.
- `clk` in 1: clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept a request.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 = byte, 01 = half, 10 = word; 11 is illegal and treated as misaligned.
- `req_unsigned` in 1: zero-extend the load when 1, sign-extend when 0.
- `req_addr` in ADDR_W: byte address.
- `req_wdata` in 32: store data, right-aligned.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out 32: extended load data; 0 for stores and errors.
- `resp_err` out 1: misaligned or illegal size; meaningful while `resp_valid` is high.
- `mem_wea` out 1: memory write enable.
- `mem_addra` out 7: memory write word address.
- `mem_dina` out 32: memory write data.
- `mem_addrb` out 7: memory read word address.
- `mem_doutb` in 32: memory read data (combinational in `addrb`; forwards `dina` while `wea` is high).

## Operation
- States: IDLE, ACCESS, WRITE, RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`, latch `we`, `size`, `unsigned`, `addr`, `wdata`.
  - Misaligned requests go to RESP with err=1; aligned requests go to ACCESS.
- Alignment rules:
  - Half needs `addr[0]`=0.
  - Word needs `addr[1:0]`=0.
  - Byte is always aligned.
- ACCESS:
  - `mem_addrb` = `mem_addra` = `addr[ADDR_W-1:2]`.
  - Word store: `mem_wea`=1, `mem_dina`=`wdata`, then go to RESP.
  - Load: `mem_wea`=0; capture the extracted and extended lane of `mem_doutb` into `resp_rdata`, then go to RESP.
  - Sub-word store: `mem_wea`=0; capture `mem_doutb` with the target lane replaced by `wdata[7:0]` or `wdata[15:0]`, then go to WRITE.
- WRITE: `mem_wea`=1, `mem_dina` = merged word, then go to RESP.
- RESP: `resp_valid`=1 for exactly one cycle, then go to IDLE.
- Lane selection is little-endian:
  - Byte lane = `addr[1:0]` (byte n occupies bits 8n+7:8n).
  - Half lane = `addr[1]`.
- Extension: replicate the MSB of the selected lane unless `req_unsigned`; zero-fill otherwise.
- `mem_wea`=0 in every state other than those listed above, and whenever `rst`=1.
- The unit never reads memory in a cycle where it asserts `mem_wea`, because of the memory's write forwarding.

## Timing
- Reset values:
  - State IDLE.
  - `resp_valid`=0, `resp_rdata`=0, `resp_err`=0.
  - `mem_wea`=0.
  - `req_ready`=0 while `rst`=1 and 1 in the first cycle after reset.
- `req_ready` is combinational: (state==IDLE) && !`rst`. It does not depend on `req_valid`.
- Handshake: a request transfers on the rising edge where `req_valid` && `req_ready`. Request inputs are sampled only at that edge.
- Latency from the accept edge to `resp_valid` high:
  - Load: 2 cycles.
  - Word store: 2 cycles.
  - Sub-word store: 3 cycles.
  - Misaligned request: 1 cycle.
- Throughput: one request per latency + 1 cycles. There is no pipelining and no back-to-back acceptance during RESP.
- `resp_rdata` and `resp_err` are held until the next accept. `resp_valid` is a single-cycle pulse with no `resp_ready`.
- Reset in any state aborts the operation, returns to IDLE, and issues no response.
  - A sub-word store aborted in ACCESS leaves memory unchanged.
  - A store whose write cycle coincides with `rst`=1 is not written.

## Structure
- Shared package `mem_pkg` holds:
  - `SIZE_B`/`SIZE_H`/`SIZE_W` encodings.
  - The state encoding for IDLE, ACCESS, WRITE, RESP.
  - `WORDS`=128.
- One combinational sub-module, `lsu_align`, handles lane extraction plus extension for loads and lane merge for stores.
  - It has no state.
  - The FSM, request latches and response registers stay in `mem_access_unit`.

## Test plan
- Word store, then load:
  - Store `addr`=0x010, `wdata`=0xDEADBEEF.
  - Required: `mem_wea` pulses 1 cycle with `addra`=4; `resp_valid` 2 cycles after accept.
  - Load word at 0x010 returns 0xDEADBEEF with err=0.
- Byte load extension, with word 4 = 0x80FF7F01:
  - Signed byte load at 0x013 returns 0xFFFFFF80.
  - Unsigned byte load at 0x013 returns 0x00000080.
  - Signed half load at 0x012 returns 0xFFFF80FF.
- Sub-word store read-modify-write:
  - Word 5 = 0x11223344; store byte 0xAA at 0x015.
  - Required: no `wea` in ACCESS, `wea` in WRITE with `dina`=0x1122AA44, `resp_valid` 3 cycles after accept.
  - Reading word 5 then returns 0x1122AA44.
- Misaligned requests:
  - Word at 0x012, half at 0x011, and `size`=11: each gives `resp_valid` 1 cycle after accept with err=1 and rdata=0.
  - `mem_wea` never asserts.
- Handshake:
  - Hold `req_valid`=1 with two queued requests; `req_ready` must drop after each accept and rise only in IDLE.
  - Exactly two accepts and two responses occur in order.
- Reset mid-operation:
  - Assert `rst` during ACCESS of a half store to 0x020 over word 8 = 0xCAFEF00D.
  - Required: no `resp_valid` pulse, and word 8 still reads 0xCAFEF00D.
  - `req_ready`=1 in the first cycle after `rst` deasserts.
